// File: rtl/complex_tridiag_mvm_stream.sv
// Streaming y = A*x for a complex tridiagonal A, one group of NUM_UNITS rows per pass.
// Define CMVM_CONJ_EN to add the conj_mat input, which computes y = conj(A)*x instead.
module complex_tridiag_mvm_stream #(
    parameter int N_EQN     = 3,
    parameter int NUM_UNITS = 4,
    parameter int ELEM_W    = 64,
    localparam int N_MAT    = 3 * N_EQN - 2,
    localparam int N_GRP    = (N_EQN + NUM_UNITS - 1) / NUM_UNITS,
    localparam int RES_H    = ELEM_W + 3,
    localparam int GW       = $clog2(N_GRP) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
`ifdef CMVM_CONJ_EN
    input  logic                         conj_mat,
`endif
    input  logic [ELEM_W*N_MAT-1:0]      mat,
    input  logic [ELEM_W*N_EQN-1:0]      vector,
    output logic                         busy,
    output logic                         done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_UNITS*2*RES_H-1:0] out_data,
    output logic [NUM_UNITS-1:0]         out_lane_valid,
    output logic [GW-1:0]                out_group
);

    localparam int H  = ELEM_W / 2;
    localparam int PW = ELEM_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_SUM, S_OUT} state_t;

    state_t          state;
    logic [GW-1:0]   grp;
    logic [1:0]      rst_q;
    logic            conj_q;

    // Band element / vector element per row; index 0 = lower, 1 = diag, 2 = upper.
    logic [ELEM_W-1:0] row_m [N_EQN][3];
    logic [ELEM_W-1:0] row_x [N_EQN][3];

    for (genvar r = 0; r < N_EQN; r++) begin : g_row
        assign row_m[r][1] = mat[3*r*ELEM_W +: ELEM_W];
        assign row_x[r][1] = vector[r*ELEM_W +: ELEM_W];
        if (r > 0) begin : g_lo
            assign row_m[r][0] = mat[(3*r-1)*ELEM_W +: ELEM_W];
            assign row_x[r][0] = vector[(r-1)*ELEM_W +: ELEM_W];
        end else begin : g_no_lo
            assign row_m[r][0] = '0;
            assign row_x[r][0] = '0;
        end
        if (r < N_EQN - 1) begin : g_up
            assign row_m[r][2] = mat[(3*r+1)*ELEM_W +: ELEM_W];
            assign row_x[r][2] = vector[(r+1)*ELEM_W +: ELEM_W];
        end else begin : g_no_up
            assign row_m[r][2] = '0;
            assign row_x[r][2] = '0;
        end
    end

    logic [ELEM_W-1:0]    sel_m [NUM_UNITS][3];
    logic [ELEM_W-1:0]    sel_x [NUM_UNITS][3];
    logic [NUM_UNITS-1:0] sel_mask;

    // Padded lanes keep all-zero operands, so they naturally produce zero.
    always_comb begin
        sel_mask = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int k = 0; k < 3; k++) begin
                sel_m[u][k] = '0;
                sel_x[u][k] = '0;
            end
            for (int r = 0; r < N_EQN; r++) begin
                if (int'(grp) * NUM_UNITS + u == r) begin
                    sel_mask[u] = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        sel_m[u][k] = row_m[r][k];
                        sel_x[u][k] = row_x[r][k];
                    end
                end
            end
        end
    end

    function automatic logic signed [H:0] sx(input logic [H-1:0] v);
        return {v[H-1], v};
    endfunction

    function automatic logic signed [PW-1:0] smul(input logic signed [H:0] a,
                                                  input logic signed [H:0] b);
        return PW'(a) * PW'(b);
    endfunction

    logic signed [H:0] a_re [NUM_UNITS][3];
    logic signed [H:0] a_im [NUM_UNITS][3];
    logic signed [H:0] b_re [NUM_UNITS][3];
    logic signed [H:0] b_im [NUM_UNITS][3];

    // Operands are widened to H+1 bits before conjugation so -(-2^(H-1)) is exact.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                for (int k = 0; k < 3; k++) begin
                    a_re[u][k] <= sx(sel_m[u][k][ELEM_W-1:H]);
                    a_im[u][k] <= conj_q ? -sx(sel_m[u][k][H-1:0]) : sx(sel_m[u][k][H-1:0]);
                    b_re[u][k] <= sx(sel_x[u][k][ELEM_W-1:H]);
                    b_im[u][k] <= sx(sel_x[u][k][H-1:0]);
                end
            end
        end
    end

    logic signed [PW-1:0] p_rr [NUM_UNITS][3];
    logic signed [PW-1:0] p_ii [NUM_UNITS][3];
    logic signed [PW-1:0] p_ri [NUM_UNITS][3];
    logic signed [PW-1:0] p_ir [NUM_UNITS][3];

    always_ff @(posedge clk) begin
        if (state == S_MUL) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                for (int k = 0; k < 3; k++) begin
                    p_rr[u][k] <= smul(a_re[u][k], b_re[u][k]);
                    p_ii[u][k] <= smul(a_im[u][k], b_im[u][k]);
                    p_ri[u][k] <= smul(a_re[u][k], b_im[u][k]);
                    p_ir[u][k] <= smul(a_im[u][k], b_re[u][k]);
                end
            end
        end
    end

    logic signed [RES_H-1:0] lane_re [NUM_UNITS];
    logic signed [RES_H-1:0] lane_im [NUM_UNITS];

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            lane_re[u] = '0;
            lane_im[u] = '0;
            for (int k = 0; k < 3; k++) begin
                lane_re[u] = lane_re[u] + RES_H'(p_rr[u][k]) - RES_H'(p_ii[u][k]);
                lane_im[u] = lane_im[u] + RES_H'(p_ri[u][k]) + RES_H'(p_ir[u][k]);
            end
        end
    end

    // Reset assertion is immediate; release is seen by the FSM two edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            grp            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_lane_valid <= '0;
            out_group      <= '0;
`ifdef CMVM_CONJ_EN
            conj_q         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is deliberately dropped.
                    if (start && rst_q[1] && !done) begin
                        state <= S_LOAD;
                        grp   <= '0;
                        busy  <= 1'b1;
`ifdef CMVM_CONJ_EN
                        conj_q <= conj_mat;
`endif
                    end
                end
                S_LOAD: state <= S_MUL;
                S_MUL:  state <= S_SUM;
                S_SUM: begin
                    for (int u = 0; u < NUM_UNITS; u++) begin
                        out_data[u*2*RES_H +: 2*RES_H] <= {lane_re[u], lane_im[u]};
                    end
                    out_lane_valid <= sel_mask;
                    out_group      <= grp;
                    out_valid      <= 1'b1;
                    state          <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (grp == GW'(N_GRP - 1)) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            grp   <= grp + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef CMVM_CONJ_EN
    assign conj_q = 1'b0;
`endif

endmodule

// File: tb/tb_complex_tridiag_mvm_stream.sv
// Bench for complex_tridiag_mvm_stream: random band/vector data scored against a
// row-by-row complex arithmetic model, with backpressure, reset and start corner cases.
module tb_complex_tridiag_mvm_stream;

    localparam int N_EQN     = 10;
    localparam int NUM_UNITS = 4;
    localparam int ELEM_W    = 64;
    localparam int N_MAT     = 3 * N_EQN - 2;
    localparam int N_GRP     = (N_EQN + NUM_UNITS - 1) / NUM_UNITS;
    localparam int RES_H     = ELEM_W + 3;
    localparam int GW        = $clog2(N_GRP) + 1;
    localparam int LW        = 2 * RES_H;
    localparam int DW        = NUM_UNITS * LW;
    localparam int W         = GW + NUM_UNITS + DW;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic [ELEM_W*N_MAT-1:0] mat;
    logic [ELEM_W*N_EQN-1:0] vector;
    logic                    busy;
    logic                    done;
    logic                    out_valid;
    logic                    out_ready;
    logic [DW-1:0]           out_data;
    logic [NUM_UNITS-1:0]    out_lane_valid;
    logic [GW-1:0]           out_group;
`ifdef CMVM_CONJ_EN
    logic                    conj_mat;
`endif

    complex_tridiag_mvm_stream #(
        .N_EQN(N_EQN), .NUM_UNITS(NUM_UNITS), .ELEM_W(ELEM_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef CMVM_CONJ_EN
        .conj_mat(conj_mat),
`endif
        .mat(mat),
        .vector(vector),
        .busy(busy),
        .done(done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_lane_valid(out_lane_valid),
        .out_group(out_group)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    int           acc_cnt;
    int           stall_cnt;
    int           hold;
    int           ready_mode;
    logic [DW-1:0] first_data;

    int m_re[N_MAT];
    int m_im[N_MAT];
    int x_re[N_EQN];
    int x_im[N_EQN];
    bit conj_b;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: y_r = sum over existing neighbours of A[r][c]*x[c], in 128-bit.
    function automatic logic signed [127:0] sx128(input int v);
        return 128'(v);
    endfunction

    task automatic push_expected();
        logic [DW-1:0]          d;
        logic [NUM_UNITS-1:0]   m;
        logic signed [127:0]    re, im, ar, ai, br, bi;
        int                     r, c;
        for (int g = 0; g < N_GRP; g++) begin
            d = '0;
            m = '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                r  = g * NUM_UNITS + u;
                re = '0;
                im = '0;
                if (r < N_EQN) begin
                    m[u] = 1'b1;
                    for (int j = -1; j <= 1; j++) begin
                        c = r + j;
                        if (c >= 0 && c < N_EQN) begin
                            ar = sx128(m_re[3*r+j]);
                            ai = sx128(m_im[3*r+j]);
                            if (conj_b) ai = -ai;
                            br = sx128(x_re[c]);
                            bi = sx128(x_im[c]);
                            re = re + ar * br - ai * bi;
                            im = im + ar * bi + ai * br;
                        end
                    end
                end
                d[u*LW +: LW] = {re[RES_H-1:0], im[RES_H-1:0]};
            end
            exp_q.push_back({GW'(g), m, d});
        end
    endtask

    // Driver tasks
    task automatic apply_inputs();
        for (int k = 0; k < N_MAT; k++) mat[k*ELEM_W +: ELEM_W] = {m_re[k], m_im[k]};
        for (int r = 0; r < N_EQN; r++) vector[r*ELEM_W +: ELEM_W] = {x_re[r], x_im[r]};
`ifdef CMVM_CONJ_EN
        conj_mat = conj_b;
`endif
    endtask

    task automatic rand_data();
        for (int k = 0; k < N_MAT; k++) begin
            m_re[k] = int'($urandom);
            m_im[k] = int'($urandom);
        end
        for (int r = 0; r < N_EQN; r++) begin
            x_re[r] = int'($urandom);
            x_im[r] = int'($urandom);
        end
    endtask

    task automatic run_op(input int mode, input bit poke_busy, input bit poke_done);
        int n;
        ready_mode = mode;
        hold       = 0;
        acc_cnt    = 0;
        stall_cnt  = 0;
        apply_inputs();
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_after_start", busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_valid_latency", n, 3);
        while (!done && n < 400) begin
            start = poke_busy && (n == 6);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("groups_before_done", acc_cnt, N_GRP);
        check("queue_drained", exp_q.size(), 0);
        check("busy_at_done", busy, 0);
        if (mode == 0) check("cycles_to_done", n, 4 * N_GRP);
        if (mode == 2) check("stall_cycles_group1", stall_cnt, 5);
        exp_q.delete();
        start = poke_done;
        @(posedge clk); #1 start = 1'b0;
        check("done_one_cycle", done, 0);
        repeat (6) @(posedge clk);
        #1;
        check("idle_after_done", {busy, out_valid}, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {busy, done, out_valid, out_lane_valid, out_group}, 0);
        check({name, "_data"}, out_data == '0, 1);
    endtask

    // Ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && out_group == GW'(1) && hold < 5) begin
                        out_ready = 1'b0;
                        hold++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Scoreboard monitor
    logic         stall_pending = 1'b0;
    logic [W-1:0] held;
    logic [W-1:0] got;
    logic [W-1:0] exp;

    always @(negedge clk) begin
        got = {out_group, out_lane_valid, out_data};
        if (!reset) begin
            stall_pending = 1'b0;
        end else if (out_valid) begin
            if (stall_pending) begin
                checks++;
                stall_cnt++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL hold_stable: got %0h held %0h", got, held);
                end
            end
            if (out_ready) begin
                checks++;
                acc_cnt++;
                stall_pending = 1'b0;
                if (out_group == '0) first_data = out_data;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_group: got group %0d mask %b", out_group, out_lane_valid);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL group_result: got %0h expected %0h", got, exp);
                    end
                end
            end else begin
                stall_pending = 1'b1;
                held          = got;
            end
        end else if (stall_pending) begin
            checks++;
            errors++;
            stall_pending = 1'b0;
            $display("FAIL valid_dropped: got out_valid 0 expected 1");
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        ready_mode = 0;
        conj_b     = 1'b0;
        first_data = '0;
        mat        = '0;
        vector     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b1;
        @(posedge clk);

        // Identity band with random x
        rand_data();
        for (int k = 0; k < N_MAT; k++) begin
            m_re[k] = 0;
            m_im[k] = 0;
        end
        for (int r = 0; r < N_EQN; r++) m_re[3*r] = 1;
        run_op(0, 1'b0, 1'b0);

        // Hand-computed row 1: (0+1j)(1) + 2(1+1j) + (1-1j)(0+1j) = 3+4j
        rand_data();
        m_re[2] = 0;  m_im[2] = 1;
        m_re[3] = 2;  m_im[3] = 0;
        m_re[4] = 1;  m_im[4] = -1;
        x_re[0] = 1;  x_im[0] = 0;
        x_re[1] = 1;  x_im[1] = 1;
        x_re[2] = 0;  x_im[2] = 1;
        run_op(1, 1'b0, 1'b0);
        check("band_row1_lane", first_data[LW +: LW], {67'd3, 67'd4});

        // Backpressure on group 1 plus a start pulse while busy
        rand_data();
        run_op(2, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            rand_data();
            run_op(1, 1'b0, (i == 3));
        end

        // Most negative halves everywhere
        for (int k = 0; k < N_MAT; k++) begin
            m_re[k] = int'(32'h8000_0000);
            m_im[k] = int'(32'h8000_0000);
        end
        for (int r = 0; r < N_EQN; r++) begin
            x_re[r] = int'(32'h8000_0000);
            x_im[r] = int'(32'h8000_0000);
        end
        run_op(0, 1'b0, 1'b0);

        // Reset while group 1 is in the multiply stage
        rand_data();
        ready_mode = 0;
        acc_cnt    = 0;
        apply_inputs();
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid_op");
        check("groups_before_reset", acc_cnt, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        rand_data();
        run_op(0, 1'b0, 1'b0);

`ifdef CMVM_CONJ_EN
        for (int k = 0; k < N_MAT; k++) begin
            m_re[k] = 0;
            m_im[k] = 0;
        end
        for (int r = 0; r < N_EQN; r++) begin
            m_im[3*r] = 1;
            x_re[r]   = 1;
            x_im[r]   = 0;
        end
        conj_b = 1'b1;
        run_op(0, 1'b0, 1'b0);
        check("conj_lane0", first_data[LW-1:0], {{RES_H{1'b0}}, {RES_H{1'b1}}});
        conj_b = 1'b0;
        run_op(0, 1'b0, 1'b0);
        check("noconj_lane0", first_data[LW-1:0], {67'd0, 67'd1});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
